regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width in bits.
REQ-002 Parameter NREG, default 32: register count, power of two >= 2; AW = $clog2(NREG).
REQ-003 Parameter NRD, default 2: number of read ports.
REQ-004 Parameter NWR, default 1: number of write ports.
REQ-005 Parameter BYPASS, default 1: 1 = same-cycle write data forwarded to reads; 0 = reads return stored value.
REQ-006 clk  in  1: single clock, rising edge.
REQ-007 nrst  in  1: reset, synchronous and active-low.
REQ-008 raddr  in  NRD*AW: read addresses, port i at slice i.
REQ-009 rdata  out  NRD*XLEN: read data, combinational from raddr.
REQ-010 rbusy  out  NRD: read register has a pending write, combinational.
REQ-011 wen  in  NWR: write enables.
REQ-012 waddr  in  NWR*AW: write addresses.
REQ-013 wdata  in  NWR*XLEN: write data.
REQ-014 rsv_en  in  1: reserve request; marks a register pending.
REQ-015 rsv_addr  in  AW: register to reserve.
REQ-016 busy_cnt  out  AW+1: count of pending registers, registered.

Function
REQ-017 Register 0 SHALL read as zero on every port, ignore writes, never be pending, and report rbusy=0.
REQ-018 A write SHALL update reg[waddr[k]] on the rising clk edge when wen[k]=1; write latency 1 cycle.
REQ-019 When several ports write the same address in one cycle, the highest-index port SHALL win, both for storage and for bypass.
REQ-020 With BYPASS=1, a read of an address written in the same cycle SHALL return the winning wdata; with BYPASS=0, it SHALL return the stored value.
REQ-021 rsv_en=1 with rsv_addr!=0 SHALL set busy[rsv_addr] at the next edge.
REQ-022 A write to a nonzero address SHALL clear busy[waddr] at the next edge.
REQ-023 Reserve and write to the same address in one cycle: busy SHALL remain 1 (reserve wins; the new producer is outstanding).
REQ-024 Reserving an already-busy register SHALL leave it busy; no error, no count change.
REQ-025 A write to a non-busy register SHALL be legal and leave busy at 0.
REQ-026 rbusy[i] SHALL equal busy[raddr[i]]; with BYPASS=1 it SHALL be forced 0 when that address is written in the same cycle; a same-cycle reserve SHALL NOT affect rbusy until the next cycle.
REQ-027 busy_cnt SHALL equal the population count of busy after each edge, range 0..NREG-1, no wrap.

Reset
REQ-028 With nrst=0 at a rising edge, registers 1..NREG-1 SHALL clear to 0, all busy bits SHALL clear, and busy_cnt SHALL be 0.
REQ-029 During reset cycles, writes and reserves SHALL be ignored; reset mid-operation discards all pending state.
REQ-030 rdata SHALL read 0 for every address after reset; rbusy SHALL be 0.

Structure
REQ-031 Package regfile_pkg SHALL hold default parameter constants (XLEN, NREG, NRD, NWR) and the register-index typedef.
REQ-032 The per-port read path (zero check, bypass priority mux, rbusy masking) SHALL be sub-module rf_read_port, instantiated NRD times by generate.
REQ-033 Storage and busy bits SHALL be flops only, with no latches and no inferred memory macro.

Verification
REQ-034 Reset, then write x5=0xDEADBEEF; next cycle read x5 -> 0xDEADBEEF; read x0 -> 0.
REQ-035 Write x0=0x1234 plus reserve x0 -> rdata for x0 stays 0, rbusy=0, busy_cnt=0.
REQ-036 NWR=2, both ports write x7 (0x11, 0x22) with BYPASS=1; same-cycle read -> 0x22; next cycle read -> 0x22.
REQ-037 Reserve x3 -> next cycle rbusy=1, busy_cnt=1; write x3=0x55 while reading x3 -> rdata=0x55, rbusy=0 (BYPASS=1); following cycle busy_cnt=0.
REQ-038 Reserve x9 and write x9 in the same cycle -> x9 busy next cycle, busy_cnt=1; BYPASS=0, then write x9=0xA5 and read x9 same cycle -> old value, rbusy=1.
REQ-039 Reserve x1..x4, assert nrst=0 for one cycle -> busy_cnt=0, all rbusy=0, x1..x4 read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Purpose: shared defaults and types for the scoreboarded register file.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package regfile_pkg;

  // Default geometry: 32 x 32-bit registers, 2 read ports, 1 write port.
  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NRD  = 2;
  localparam int RF_NWR  = 1;
  localparam int RF_AW   = $clog2(RF_NREG);

  // Register index for the default geometry.
  typedef logic [RF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// Purpose: one read port: x0 zero check, same-cycle write bypass, rbusy masking.
// Latency: combinational from raddr/write inputs to rdata/rbusy.
// Backpressure: none; a read is always answered in the same cycle.
//
// Ports:
//   raddr        register index being read
//   stored       storage value of reg[raddr], selected by the parent
//   stored_busy  scoreboard bit of reg[raddr], selected by the parent
//   wen/waddr/wdata  this cycle's write ports (already gated by reset)
//   rdata/rbusy  resolved read data and pending flag
module rf_read_port import regfile_pkg::*; #(
  parameter int XLEN   = RF_XLEN,
  parameter int AW     = RF_AW,
  parameter int NWR    = RF_NWR,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]       raddr,
  input  logic [XLEN-1:0]     stored,
  input  logic                stored_busy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  output logic [XLEN-1:0]     rdata,
  output logic                rbusy
);

  logic            hit;
  logic [XLEN-1:0] fwd;
  logic            is_zero;

  // Ascending scan so the highest-index matching write port overrides
  // lower ones, matching the storage update order in the parent.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int k = 0; k < NWR; k++) begin
      if (wen[k] && (waddr[k*AW +: AW] == raddr)) begin
        hit = 1'b1;
        fwd = wdata[k*XLEN +: XLEN];
      end
    end
  end

  assign is_zero = (raddr == '0);

  always_comb begin
    rdata = stored;
    rbusy = stored_busy;
    if (is_zero) begin
      // x0 is hard-wired: never data, never pending.
      rdata = '0;
      rbusy = 1'b0;
    end else if ((BYPASS != 0) && hit) begin
      // The write landing this cycle is the outstanding producer, so the
      // value is available now and the register is no longer pending.
      rdata = fwd;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Purpose: multi-port register file with a per-register pending (scoreboard) bit.
// Latency: writes/reserves take effect at the next clk edge; reads are combinational.
// Backpressure: none; every write, reserve and read is accepted every cycle.
//
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   raddr/rdata/rbusy    NRD read ports, data and pending flag per port
//   wen/waddr/wdata      NWR write ports, highest index wins on collisions
//   rsv_en/rsv_addr      mark a register pending (new producer issued)
//   busy_cnt             registered count of pending registers
module regfile_sb import regfile_pkg::*; #(
  parameter  int XLEN   = RF_XLEN,
  parameter  int NREG   = RF_NREG,
  parameter  int NRD    = RF_NRD,
  parameter  int NWR    = RF_NWR,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NWR-1:0]  wen_eff;

  // Writes presented while in reset are dropped, so the read ports must
  // not forward them either.
  assign wen_eff = wen & {NWR{nrst}};

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Scoreboard next state: writes retire, then a reserve re-arms. Ordering
  // matters when both hit one register: the reserve names a newer producer.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWR; k++) begin
      if (wen[k]) begin
        busy_nxt[waddr[k*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  // Storage is a reset flop array. Later ports are assigned last, so the
  // highest-index port wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wen[k] && (waddr[k*AW +: AW] != '0)) begin
          regs[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];

    rf_read_port #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_port (
      .raddr       (ra),
      .stored      (regs[ra]),
      .stored_busy (busy[ra]),
      .wen         (wen_eff),
      .waddr       (waddr),
      .wdata       (wdata),
      .rdata       (rdata[i*XLEN +: XLEN]),
      .rbusy       (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Purpose: directed self-checking bench for regfile_sb, bypass and non-bypass builds.
// Latency: checks comb reads in-cycle and registered state one edge later.
// Backpressure: n/a.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                nrst;
  logic [NRD*AW-1:0]   raddr;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;

  logic [NRD*XLEN-1:0] rdata_a, rdata_b;
  logic [NRD-1:0]      rbusy_a, rbusy_b;
  logic [AW:0]         cnt_a, cnt_b;

  int n_chk;
  int n_fail;

  // u_byp: BYPASS=1; u_nob: BYPASS=0. Both see identical stimulus.
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
    .clk(clk), .nrst(nrst), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(cnt_a)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nob (
    .clk(clk), .nrst(nrst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle; inputs are changed afterwards.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wen      = '0;
    waddr    = '0;
    wdata    = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic rd(input int p, input reg_idx_t a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int k, input reg_idx_t a, input logic [XLEN-1:0] d);
    wen[k]              = 1'b1;
    waddr[k*AW +: AW]   = a;
    wdata[k*XLEN +: XLEN] = d;
  endtask

  task automatic rsv(input reg_idx_t a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    nrst   = 1'b0;
    raddr  = '0;
    idle();
    tick();
    tick();
    nrst = 1'b1;

    // Reset state
    rd(0, 5'd1); rd(1, 5'd31); #1;
    chk("rst_rdata_p0", rdata_a[31:0], 0);
    chk("rst_rdata_p1", rdata_a[63:32], 0);
    chk("rst_rbusy", rbusy_a, 0);
    chk("rst_cnt_byp", cnt_a, 0);
    chk("rst_cnt_nob", cnt_b, 0);

    // Basic write then read; x0 reads zero
    wr(0, 5'd5, 32'hDEADBEEF);
    tick(); idle();
    rd(0, 5'd5); rd(1, 5'd0); #1;
    chk("wr_x5_byp", rdata_a[31:0], 32'hDEADBEEF);
    chk("wr_x5_nob", rdata_b[31:0], 32'hDEADBEEF);
    chk("rd_x0", rdata_a[63:32], 0);

    // x0: write and reserve are both ignored
    wr(0, 5'd0, 32'h1234); rsv(5'd0); rd(0, 5'd0); #1;
    chk("x0_same_rdata", rdata_a[31:0], 0);
    chk("x0_same_rbusy", rbusy_a[0], 0);
    tick(); idle(); #1;
    chk("x0_rdata", rdata_a[31:0], 0);
    chk("x0_rbusy", rbusy_a[0], 0);
    chk("x0_cnt", cnt_a, 0);

    // Two write ports hit x7: port 1 wins
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7); #1;
    chk("coll_byp_same", rdata_a[31:0], 32'h22);
    chk("coll_nob_same", rdata_b[31:0], 32'h0);
    tick(); idle(); #1;
    chk("coll_byp_next", rdata_a[31:0], 32'h22);
    chk("coll_nob_next", rdata_b[31:0], 32'h22);

    // Reserve x3 is invisible until the next cycle
    rsv(5'd3); rd(0, 5'd3); rd(1, 5'd3); #1;
    chk("rsv_same_rbusy", rbusy_a, 2'b00);
    tick(); idle(); #1;
    chk("rsv_rbusy", rbusy_a, 2'b11);
    chk("rsv_cnt_byp", cnt_a, 1);
    chk("rsv_cnt_nob", cnt_b, 1);
    // Producer writes x3 while it is being read
    wr(0, 5'd3, 32'h55); #1;
    chk("fwd_rdata_byp", rdata_a[31:0], 32'h55);
    chk("fwd_rbusy_byp", rbusy_a[0], 0);
    chk("fwd_rdata_nob", rdata_b[31:0], 32'h0);
    chk("fwd_rbusy_nob", rbusy_b[0], 1);
    tick(); idle(); #1;
    chk("retire_cnt", cnt_a, 0);
    chk("retire_rbusy", rbusy_a[0], 0);
    chk("retire_rdata_nob", rdata_b[31:0], 32'h55);

    // Reserve and write x9 together: reserve wins
    rsv(5'd9); wr(0, 5'd9, 32'h77);
    tick(); idle(); rd(0, 5'd9); #1;
    chk("rsvwr_cnt", cnt_b, 1);
    chk("rsvwr_rbusy", rbusy_b[0], 1);
    chk("rsvwr_rdata", rdata_b[31:0], 32'h77);
    // Re-reserving a busy register changes nothing
    rsv(5'd9);
    tick(); idle(); #1;
    chk("rersv_cnt", cnt_a, 1);
    // Write to a non-busy register leaves the count alone
    wr(1, 5'd2, 32'h2);
    tick(); idle(); #1;
    chk("nonbusy_wr_cnt", cnt_a, 1);
    // BYPASS=0 returns the stored value while the write is in flight
    wr(0, 5'd9, 32'hA5); rd(0, 5'd9); #1;
    chk("nob_old_rdata", rdata_b[31:0], 32'h77);
    chk("nob_old_rbusy", rbusy_b[0], 1);
    chk("byp_new_rdata", rdata_a[31:0], 32'hA5);
    tick(); idle(); #1;
    chk("nob_new_rdata", rdata_b[31:0], 32'hA5);
    chk("nob_new_cnt", cnt_b, 0);

    // Load x1..x4, reserve them, then reset mid-operation
    wr(0, 5'd1, 32'h1); wr(1, 5'd4, 32'h4);
    tick(); idle();
    for (int i = 1; i <= 4; i++) begin
      rsv(reg_idx_t'(i));
      tick();
    end
    idle(); #1;
    chk("pre_rst_cnt", cnt_a, 4);
    nrst = 1'b0;
    wr(0, 5'd6, 32'hFF); rsv(5'd6);
    tick();
    nrst = 1'b1; idle(); #1;
    chk("mid_rst_cnt_byp", cnt_a, 0);
    chk("mid_rst_cnt_nob", cnt_b, 0);
    for (int i = 1; i <= 6; i += 2) begin
      rd(0, reg_idx_t'(i)); rd(1, reg_idx_t'(i + 1)); #1;
      chk("mid_rst_rdata_byp", rdata_a, 0);
      chk("mid_rst_rdata_nob", rdata_b, 0);
      chk("mid_rst_rbusy", {rbusy_a, rbusy_b}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
